fp_div_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider, quotient = a / b. It is the inverse

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_div_seq_if.sv | 24 ++
 rtl/fp_div_mant_iter.sv | 71 +++++++
 rtl/fp_div_seq.sv | 171 +++++++++++++++++
 tb/tb_fp_div_seq.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, FSM state encoding and flag
// bit positions for the sequential divider.
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [FP_WIDTH-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [FP_EXP_W-1:0] INF_EXP = 8'hFF;

  // Bit positions inside the {nv, dz, of, uf} flag vector
  localparam int FLAG_NV = 3;
  localparam int FLAG_DZ = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UNPK = 3'd1,
    DIV  = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the divider: master drives operands and
// out_ready, slave (the divider) returns readiness, the quotient and flags.
interface fp_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quotient, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quotient, flags
  );
endinterface

// File: rtl/fp_div_mant_iter.sv
// Restoring radix-2 mantissa divider: one quotient bit per cycle, MSB first,
// producing (dividend << (MW)) / divisor as an (MW+1)-bit quotient.
module fp_div_mant_iter #(
  parameter int MW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [MW-1:0] dividend_i,
  input  logic [MW-1:0] divisor_i,
  output logic          done_o,
  output logic [MW:0]   quot_o
);

  localparam int QW = MW + 1;
  localparam int CW = $clog2(QW);

  logic [QW-1:0] rem_q, rem_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [MW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ge_s;
  logic [MW-1:0] diff_s;

  // The remainder stays below twice the divisor, so one extra bit suffices and
  // the restored/subtracted value always fits back into MW bits.
  always_comb begin
    ge_s   = (rem_q >= {1'b0, dvs_q});
    diff_s = ge_s ? (rem_q[MW-1:0] - dvs_q) : rem_q[MW-1:0];
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = {1'b0, dividend_i};
      dvs_d  = divisor_i;
      quot_d = {QW{1'b0}};
      cnt_d  = CW'(QW - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = {diff_s, 1'b0};
      quot_d = {quot_q[QW-2:0], ge_s};
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != {CW{1'b0}});
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= {QW{1'b0}};
      quot_q <= {QW{1'b0}};
      dvs_q  <= {MW{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == {CW{1'b0}});
  assign quot_o = quot_q;

endmodule

// File: rtl/fp_div_seq.sv
// Fixed-latency IEEE-754 single-precision divider: truncating rounding,
// denormals flushed to zero, valid/ready on both sides, one op in flight.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int EXP_WIDTH = FP_EXP_W,
  parameter int MAN_WIDTH = FP_MAN_W,
  parameter int BIAS      = FP_BIAS
) (
  input logic         clk,
  input logic         rst,
  fp_div_seq_if.slave bus
);

  localparam int EW2 = EXP_WIDTH + 2;
  localparam int MW1 = MAN_WIDTH + 1;
  localparam int QW  = MAN_WIDTH + 2;

  localparam logic signed [EW2-1:0] EBIAS    = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EONE     = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_ZERO = EW2'(0);
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_WIDTH) - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0]     a_q, b_q;
  logic                 sign_q, special_q;
  logic signed [EW2-1:0] e_q;
  logic [WIDTH-1:0]     spec_res_q, quot_q;
  logic [3:0]           spec_flg_q, flags_q;

  logic                 sa_s, sb_s, sign_s;
  logic [EXP_WIDTH-1:0] ea_s, eb_s;
  logic [MAN_WIDTH-1:0] fa_s, fb_s;
  logic                 a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic signed [EW2-1:0] e_s, exp_s;
  logic                 special_s;
  logic [WIDTH-1:0]     spec_res_s, res_s;
  logic [3:0]           spec_flg_s, flg_s;
  logic [MAN_WIDTH-1:0] man_s;
  logic                 accept_s, start_s, iter_done_s;
  logic [QW-1:0]        q_s;

  assign accept_s = bus.in_valid && (state_q == IDLE);
  assign start_s  = (state_q == UNPK);

  assign sa_s     = a_q[WIDTH-1];
  assign sb_s     = b_q[WIDTH-1];
  assign ea_s     = a_q[WIDTH-2 -: EXP_WIDTH];
  assign eb_s     = b_q[WIDTH-2 -: EXP_WIDTH];
  assign fa_s     = a_q[MAN_WIDTH-1:0];
  assign fb_s     = b_q[MAN_WIDTH-1:0];
  assign sign_s   = sa_s ^ sb_s;
  assign a_zero_s = (ea_s == {EXP_WIDTH{1'b0}});
  assign b_zero_s = (eb_s == {EXP_WIDTH{1'b0}});
  assign a_nan_s  = (ea_s == INF_EXP) && (fa_s != {MAN_WIDTH{1'b0}});
  assign b_nan_s  = (eb_s == INF_EXP) && (fb_s != {MAN_WIDTH{1'b0}});
  assign a_inf_s  = (ea_s == INF_EXP) && (fa_s == {MAN_WIDTH{1'b0}});
  assign b_inf_s  = (eb_s == INF_EXP) && (fb_s == {MAN_WIDTH{1'b0}});
  assign e_s      = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + EBIAS;

  fp_div_mant_iter #(
    .MW(MW1)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_s),
    .dividend_i({1'b1, fa_s}),
    .divisor_i ({1'b1, fb_s}),
    .done_o    (iter_done_s),
    .quot_o    (q_s)
  );

  // Special-operand classification; inf/0 deliberately yields inf without dz
  always_comb begin
    special_s  = 1'b1;
    spec_res_s = {WIDTH{1'b0}};
    spec_flg_s = 4'b0000;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_res_s          = QNAN;
      spec_flg_s[FLAG_NV] = 1'b1;
    end else if (a_inf_s) begin
      spec_res_s = {sign_s, INF_EXP, {MAN_WIDTH{1'b0}}};
    end else if (b_zero_s) begin
      spec_res_s          = {sign_s, INF_EXP, {MAN_WIDTH{1'b0}}};
      spec_flg_s[FLAG_DZ] = 1'b1;
    end else if (b_inf_s || a_zero_s) begin
      spec_res_s = {sign_s, {(WIDTH-1){1'b0}}};
    end else begin
      special_s = 1'b0;
    end
  end

  // Normalise the 25-bit quotient (value in [0.5, 2)) and pack with truncation
  always_comb begin
    exp_s = q_s[QW-1] ? e_q : (e_q - EONE);
    man_s = q_s[QW-1] ? q_s[MAN_WIDTH:1] : q_s[MAN_WIDTH-1:0];
    res_s = {sign_q, exp_s[EXP_WIDTH-1:0], man_s};
    flg_s = 4'b0000;
    if (special_q) begin
      res_s = spec_res_q;
      flg_s = spec_flg_q;
    end else if (exp_s >= EXP_MAX) begin
      res_s          = {sign_q, INF_EXP, {MAN_WIDTH{1'b0}}};
      flg_s[FLAG_OF] = 1'b1;
    end else if (exp_s <= EXP_ZERO) begin
      res_s          = {sign_q, {(WIDTH-1){1'b0}}};
      flg_s[FLAG_UF] = 1'b1;
    end else begin
      flg_s = 4'b0000;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = UNPK; else state_d = IDLE;
      UNPK:    state_d = DIV;
      DIV:     if (iter_done_s) state_d = PACK; else state_d = DIV;
      PACK:    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      e_q        <= EXP_ZERO;
      spec_res_q <= {WIDTH{1'b0}};
      spec_flg_q <= 4'b0000;
      quot_q     <= {WIDTH{1'b0}};
      flags_q    <= 4'b0000;
    end else begin
      if (accept_s) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        flags_q <= 4'b0000;
      end
      if (state_q == UNPK) begin
        sign_q     <= sign_s;
        special_q  <= special_s;
        e_q        <= e_s;
        spec_res_q <= spec_res_s;
        spec_flg_q <= spec_flg_s;
      end
      if (state_q == PACK) begin
        quot_q  <= res_s;
        flags_q <= flg_s;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed vectors, specials, random
// operands against an arithmetic reference, backpressure and mid-op reset.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fp_div_seq_if #(.WIDTH(32)) bus ();

  fp_div_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: IEEE single divide with truncation and flush-to-zero
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [3:0] f);
    int     ea, eb, e;
    logic   s, az, bz, ai, bi, an, bn;
    longint num, den, qi;
    logic [22:0] man;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    az = (ea == 0);
    bz = (eb == 0);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    ai = (ea == 255) && !an;
    bi = (eb == 255) && !bn;
    f  = 4'b0000;
    if (an || bn || (az && bz) || (ai && bi)) begin
      q = 32'h7FC0_0000; f = 4'b1000;
    end else if (ai) begin
      q = {s, 8'hFF, 23'd0};
    end else if (bz) begin
      q = {s, 8'hFF, 23'd0}; f = 4'b0100;
    end else if (bi || az) begin
      q = {s, 31'd0};
    end else begin
      num = longint'({1'b1, a[22:0]}) * 64'd16777216;
      den = longint'({1'b1, b[22:0]});
      qi  = num / den;
      e   = ea - eb + 127;
      if (qi >= 64'd16777216) begin
        man = 23'(qi / 2);
      end else begin
        man = 23'(qi);
        e   = e - 1;
      end
      if (e >= 255) begin
        q = {s, 8'hFF, 23'd0}; f = 4'b0010;
      end else if (e <= 0) begin
        q = {s, 31'd0}; f = 4'b0001;
      end else begin
        q = {s, 8'(e), man};
      end
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [3:0] f,
                        output int lat, output logic [3:0] f_acc);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    f_acc        = bus.flags;
    lat          = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = bus.quotient;
    f = bus.flags;
  endtask

  task automatic pop();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.quotient !== 32'h0 || bus.flags !== 4'h0) begin
      failures++;
      $display("FAIL reset_out quotient=%h flags=%b want 0/0", bus.quotient, bus.flags);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va[6] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb[6] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h40000000};
    logic [31:0] vq[6] = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [3:0]  vf[6] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
    logic [31:0] q;
    logic [3:0]  f, fa;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], q, f, lat, fa);
      checks++;
      if (lat !== 27) begin
        failures++;
        $display("FAIL dir_latency[%0d] got=%0d want=27", i, lat);
      end
      checks++;
      if (q !== vq[i] || f !== vf[i]) begin
        failures++;
        $display("FAIL dir_result[%0d] got=%h/%b want=%h/%b", i, q, f, vq[i], vf[i]);
      end
      checks++;
      if (fa !== 4'b0000) begin
        failures++;
        $display("FAIL dir_flag_clear[%0d] got=%b want=0000", i, fa);
      end
      pop();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL dir_release[%0d] in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va[10] = '{32'h7F800000, 32'h40000000, 32'h00000000, 32'hFF800000, 32'h7FC12345,
                            32'h3F800000, 32'h7F800000, 32'h80000000, 32'h00412345, 32'hC0A00000};
    logic [31:0] vb[10] = '{32'h40000000, 32'hFF800000, 32'h40A00000, 32'h00000000, 32'h3F800000,
                            32'hFF800001, 32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h80001234};
    logic [31:0] q, eq;
    logic [3:0]  f, ef, fa;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      ref_div(va[i], vb[i], eq, ef);
      run_op(va[i], vb[i], q, f, lat, fa);
      checks++;
      if (q !== eq || f !== ef || lat !== 27) begin
        failures++;
        $display("FAIL special[%0d] got=%h/%b lat=%0d want=%h/%b lat=27", i, q, f, lat, eq, ef);
      end
      pop();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, eq;
    logic [3:0]  f, ef, fa;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      b = $urandom();
      if ((i % 4) != 3) begin
        a[30:23] = 8'($urandom_range(1, 254));
        b[30:23] = 8'($urandom_range(1, 254));
      end
      ref_div(a, b, eq, ef);
      run_op(a, b, q, f, lat, fa);
      checks++;
      if (q !== eq || f !== ef) begin
        failures++;
        $display("FAIL random[%0d] a=%h b=%h got=%h/%b want=%h/%b", i, a, b, q, f, eq, ef);
      end
      pop();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q, eq;
    logic [3:0]  f, ef, fa;
    int          lat;
    run_op(32'h40C00000, 32'h40000000, q, f, lat, fa);
    @(negedge clk);
    bus.a        = 32'h3F800000;
    bus.b        = 32'h40400000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.quotient !== 32'h40400000 || bus.flags !== 4'b0000 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure[%0d] q=%h f=%b ov=%b ir=%b want 40400000/0000/1/0",
                 i, bus.quotient, bus.flags, bus.out_valid, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    pop();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    ref_div(32'h40E00000, 32'h40000000, eq, ef);
    run_op(32'h40E00000, 32'h40000000, q, f, lat, fa);
    checks++;
    if (q !== eq || f !== ef) begin
      failures++;
      $display("FAIL bp_next got=%h/%b want=%h/%b", q, f, eq, ef);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    logic [3:0]  f, fa;
    int          lat;
    @(negedge clk);
    bus.a        = 32'h3F800000;
    bus.b        = 32'h40400000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_hs in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    run_op(32'h40C00000, 32'h40000000, q, f, lat, fa);
    checks++;
    if (q !== 32'h40400000 || f !== 4'b0000 || lat !== 27) begin
      failures++;
      $display("FAIL midreset_next got=%h/%b lat=%0d want=40400000/0000 lat=27", q, f, lat);
    end
    pop();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    test_reset();
    test_directed();
    test_specials();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
